// File: rtl/c7bbiu_axi_rd_engine.sv
// AXI read-path engine: round-robin arbitration of NUM_SRC read requesters onto one AR channel, per-source R beat tracking.
// Latency: request accepted in cycle N -> AR valid in N+1; R beat accepted in cycle M -> rsp_* registered in M+1.
// Backpressure: AR beat held stable until ext_biu_ar_ready; req_rdy low while AR slot occupied; R is always accepted (r_ready=1).
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   req_val/addr/len/size/burst  per-source request bundles (source i in slice i)
//   req_rdy                      one-hot combinational grant
//   biu_ext_ar_* / ext_biu_ar_*  AXI AR channel (id = source index)
//   ext_biu_r_* / biu_ext_r_*    AXI R channel
//   rsp_val/data/last/err        registered per-beat response, rsp_val one-hot by owning source
//   busy                         per-source burst in flight
//   proto_err                    one-cycle pulse on slave protocol violation
module c7bbiu_axi_rd_engine #(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      req_val,
  input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
  input  logic [NUM_SRC*8-1:0]    req_len,
  input  logic [NUM_SRC*3-1:0]    req_size,
  input  logic [NUM_SRC*2-1:0]    req_burst,
  output logic [NUM_SRC-1:0]      req_rdy,
  input  logic                    ext_biu_ar_ready,
  output logic                    biu_ext_ar_valid,
  output logic [ID_W-1:0]         biu_ext_ar_id,
  output logic [ADDR_W-1:0]       biu_ext_ar_addr,
  output logic [7:0]              biu_ext_ar_len,
  output logic [2:0]              biu_ext_ar_size,
  output logic [1:0]              biu_ext_ar_burst,
  output logic                    biu_ext_ar_lock,
  output logic [3:0]              biu_ext_ar_cache,
  output logic [2:0]              biu_ext_ar_prot,
  output logic                    biu_ext_r_ready,
  input  logic                    ext_biu_r_valid,
  input  logic [ID_W-1:0]         ext_biu_r_id,
  input  logic [DATA_W-1:0]       ext_biu_r_data,
  input  logic                    ext_biu_r_last,
  input  logic [1:0]              ext_biu_r_resp,
  output logic [NUM_SRC-1:0]      rsp_val,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_last,
  output logic                    rsp_err,
  output logic [NUM_SRC-1:0]      busy,
  output logic                    proto_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] LAST_SRC   = PTR_W'(NUM_SRC - 1);
  localparam logic [ID_W:0]    NUM_SRC_ID = (ID_W + 1)'(NUM_SRC);

  // AR register
  logic              ar_valid_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;

  // per-source burst tracking
  logic [NUM_SRC-1:0] busy_q;
  logic [NUM_SRC-1:0] err_q;
  logic [7:0]         len_q      [NUM_SRC];
  logic [7:0]         beat_cnt_q [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_q;

  // registered response
  logic [NUM_SRC-1:0] rsp_val_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_last_q;
  logic               rsp_err_q;
  logic               proto_err_q;

  // grant path
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] gnt;
  logic               slot_free;
  logic               found;
  logic               grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_len;
  logic [2:0]         sel_size;
  logic [1:0]         sel_burst;

  always_comb begin : grant_scan
    int idx;
    idx       = 0;
    elig      = req_val & ~busy_q;
    slot_free = ~ar_valid_q | ext_biu_ar_ready;
    found     = 1'b0;
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    // first eligible source at or after the pointer, wrapping upward
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        gnt_idx   = PTR_W'(idx);
        sel_addr  = req_addr[idx*ADDR_W +: ADDR_W];
        sel_len   = req_len[idx*8 +: 8];
        sel_size  = req_size[idx*3 +: 3];
        sel_burst = req_burst[idx*2 +: 2];
      end
    end
    grant = slot_free & found;
    gnt   = '0;
    if (grant) gnt[gnt_idx] = 1'b1;
    rr_ptr_nxt = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
  end

  // R decode
  logic             r_in_range;
  logic [PTR_W-1:0] r_src;
  logic             r_hit;
  logic             r_cnt_eq;
  logic             r_term;
  logic             r_mismatch;
  logic             r_resp_err;

  always_comb begin
    r_in_range = ({1'b0, ext_biu_r_id} < NUM_SRC_ID);
    r_src      = ext_biu_r_id[PTR_W-1:0];
    r_hit      = ext_biu_r_valid & r_in_range & busy_q[r_src];
    r_cnt_eq   = (beat_cnt_q[r_src] == len_q[r_src]);
    // a burst ends on last or on reaching its length; disagreement between the two is a slave violation
    r_term     = ext_biu_r_last | r_cnt_eq;
    r_mismatch = ext_biu_r_last ^ r_cnt_eq;
    r_resp_err = |ext_biu_r_resp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q  <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      busy_q      <= '0;
      err_q       <= '0;
      rr_ptr_q    <= '0;
      rsp_val_q   <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        len_q[i]      <= '0;
        beat_cnt_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        ar_valid_q <= 1'b1;
        ar_id_q    <= ID_W'(gnt_idx);
        ar_addr_q  <= sel_addr;
        ar_len_q   <= sel_len;
        ar_size_q  <= sel_size;
        ar_burst_q <= sel_burst;
        rr_ptr_q   <= rr_ptr_nxt;
      end else if (ext_biu_ar_ready) begin
        ar_valid_q <= 1'b0;
      end

      rsp_val_q   <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      proto_err_q <= ext_biu_r_valid & ~r_hit;
      if (r_hit) begin
        rsp_val_q[r_src] <= 1'b1;
        rsp_data_q       <= ext_biu_r_data;
        rsp_last_q       <= r_term;
        rsp_err_q        <= r_term & (err_q[r_src] | r_resp_err | r_mismatch);
        proto_err_q      <= r_mismatch;
      end

      // grant and termination never coincide for one source: grant needs ~busy
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gnt[i]) begin
          busy_q[i]     <= 1'b1;
          len_q[i]      <= sel_len;
          beat_cnt_q[i] <= '0;
          err_q[i]      <= 1'b0;
        end else if (r_hit && (r_src == PTR_W'(i))) begin
          beat_cnt_q[i] <= beat_cnt_q[i] + 8'd1;
          err_q[i]      <= err_q[i] | r_resp_err;
          if (r_term) busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign req_rdy          = gnt;
  assign biu_ext_ar_valid = ar_valid_q;
  assign biu_ext_ar_id    = ar_id_q;
  assign biu_ext_ar_addr  = ar_addr_q;
  assign biu_ext_ar_len   = ar_len_q;
  assign biu_ext_ar_size  = ar_size_q;
  assign biu_ext_ar_burst = ar_burst_q;
  assign biu_ext_ar_lock  = 1'b0;
  assign biu_ext_ar_cache = 4'd0;
  assign biu_ext_ar_prot  = 3'd0;
  assign biu_ext_r_ready  = 1'b1;
  assign rsp_val          = rsp_val_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_last         = rsp_last_q;
  assign rsp_err          = rsp_err_q;
  assign busy             = busy_q;
  assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_c7bbiu_axi_rd_engine.sv
// Directed bench for c7bbiu_axi_rd_engine with hand-computed expectations.
// Latency: inputs driven 1ns after rising edge, outputs sampled 1ns after the next edge.
// Backpressure: AR stall exercised via ext_biu_ar_ready held low.
module tb_c7bbiu_axi_rd_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_val;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [5:0]  req_size;
  logic [3:0]  req_burst;
  logic [1:0]  req_rdy;
  logic        ext_biu_ar_ready;
  logic        biu_ext_ar_valid;
  logic [3:0]  biu_ext_ar_id;
  logic [31:0] biu_ext_ar_addr;
  logic [7:0]  biu_ext_ar_len;
  logic [2:0]  biu_ext_ar_size;
  logic [1:0]  biu_ext_ar_burst;
  logic        biu_ext_ar_lock;
  logic [3:0]  biu_ext_ar_cache;
  logic [2:0]  biu_ext_ar_prot;
  logic        biu_ext_r_ready;
  logic        ext_biu_r_valid;
  logic [3:0]  ext_biu_r_id;
  logic [31:0] ext_biu_r_data;
  logic        ext_biu_r_last;
  logic [1:0]  ext_biu_r_resp;
  logic [1:0]  rsp_val;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [1:0]  busy;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  c7bbiu_axi_rd_engine dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst), .req_rdy(req_rdy),
    .ext_biu_ar_ready(ext_biu_ar_ready), .biu_ext_ar_valid(biu_ext_ar_valid),
    .biu_ext_ar_id(biu_ext_ar_id), .biu_ext_ar_addr(biu_ext_ar_addr),
    .biu_ext_ar_len(biu_ext_ar_len), .biu_ext_ar_size(biu_ext_ar_size),
    .biu_ext_ar_burst(biu_ext_ar_burst), .biu_ext_ar_lock(biu_ext_ar_lock),
    .biu_ext_ar_cache(biu_ext_ar_cache), .biu_ext_ar_prot(biu_ext_ar_prot),
    .biu_ext_r_ready(biu_ext_r_ready), .ext_biu_r_valid(ext_biu_r_valid),
    .ext_biu_r_id(ext_biu_r_id), .ext_biu_r_data(ext_biu_r_data),
    .ext_biu_r_last(ext_biu_r_last), .ext_biu_r_resp(ext_biu_r_resp),
    .rsp_val(rsp_val), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int src, input logic [31:0] addr, input logic [7:0] len);
    req_addr[src*32 +: 32] = addr;
    req_len[src*8 +: 8]    = len;
    req_size[src*3 +: 3]   = 3'd2;
    req_burst[src*2 +: 2]  = 2'd1;
  endtask

  // drive one R beat for one cycle; outputs for it are visible on return
  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                      input logic [1:0] resp);
    ext_biu_r_valid = 1'b1;
    ext_biu_r_id    = id;
    ext_biu_r_data  = data;
    ext_biu_r_last  = last;
    ext_biu_r_resp  = resp;
    tick();
    ext_biu_r_valid = 1'b0;
    ext_biu_r_last  = 1'b0;
    ext_biu_r_resp  = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_val = '0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    ext_biu_ar_ready = 1'b0;
    ext_biu_r_valid = 1'b0; ext_biu_r_id = '0; ext_biu_r_data = '0;
    ext_biu_r_last = 1'b0; ext_biu_r_resp = '0;

    // ---- reset state
    do_reset();
    chk("rst_ar_valid", biu_ext_ar_valid, 0);
    chk("rst_ar_addr", biu_ext_ar_addr, 0);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_r_ready", biu_ext_r_ready, 1);
    chk("rst_ar_const", {biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot}, 0);

    // ---- single IFU burst, len 3
    set_req(0, 32'h1C00_0000, 8'd3);
    req_val = 2'b01;
    ext_biu_ar_ready = 1'b1;
    #1;
    chk("t1_req_rdy", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    chk("t1_ar_valid", biu_ext_ar_valid, 1);
    chk("t1_ar_id", biu_ext_ar_id, 0);
    chk("t1_ar_addr", biu_ext_ar_addr, 32'h1C00_0000);
    chk("t1_ar_len", biu_ext_ar_len, 3);
    chk("t1_ar_size", biu_ext_ar_size, 2);
    chk("t1_ar_burst", biu_ext_ar_burst, 1);
    chk("t1_busy", busy, 2'b01);
    tick();
    chk("t1_ar_drop", biu_ext_ar_valid, 0);
    for (int b = 0; b < 4; b++) begin
      beat(4'd0, 32'hA0 + b, b == 3, 2'd0);
      chk("t1_rsp_val", rsp_val, 2'b01);
      chk("t1_rsp_data", rsp_data, 32'hA0 + b);
      chk("t1_rsp_last", rsp_last, (b == 3) ? 1 : 0);
      chk("t1_proto", proto_err, 0);
    end
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_busy_clr", busy, 2'b00);
    tick();
    chk("t1_rsp_idle", rsp_val, 2'b00);

    // ---- AR stall with both sources requesting (pointer back at 0)
    do_reset();
    set_req(0, 32'h0000_1000, 8'd1);
    set_req(1, 32'h0000_2000, 8'd1);
    req_val = 2'b11;
    ext_biu_ar_ready = 1'b0;
    #1;
    chk("t2_gnt_ifu", req_rdy, 2'b01);
    tick();
    req_val = 2'b10;
    for (int c = 0; c < 5; c++) begin
      chk("t2_stall_rdy", req_rdy, 2'b00);
      chk("t2_stall_valid", biu_ext_ar_valid, 1);
      chk("t2_stall_id", biu_ext_ar_id, 0);
      chk("t2_stall_addr", biu_ext_ar_addr, 32'h0000_1000);
      tick();
    end
    ext_biu_ar_ready = 1'b1;
    #1;
    chk("t2_gnt_lsu", req_rdy, 2'b10);
    tick();
    req_val = 2'b00;
    chk("t2_lsu_valid", biu_ext_ar_valid, 1);
    chk("t2_lsu_id", biu_ext_ar_id, 1);
    chk("t2_lsu_addr", biu_ext_ar_addr, 32'h0000_2000);
    chk("t2_busy", busy, 2'b11);
    tick();
    chk("t2_ar_drop", biu_ext_ar_valid, 0);

    // ---- interleaved R beats
    beat(4'd1, 32'hB0, 1'b0, 2'd0);
    chk("t3_val0", rsp_val, 2'b10);
    chk("t3_last0", rsp_last, 0);
    beat(4'd0, 32'hC0, 1'b0, 2'd0);
    chk("t3_val1", rsp_val, 2'b01);
    chk("t3_data1", rsp_data, 32'hC0);
    beat(4'd1, 32'hB1, 1'b1, 2'd0);
    chk("t3_val2", rsp_val, 2'b10);
    chk("t3_last2", rsp_last, 1);
    chk("t3_err2", rsp_err, 0);
    chk("t3_busy2", busy, 2'b01);
    beat(4'd0, 32'hC1, 1'b1, 2'd0);
    chk("t3_val3", rsp_val, 2'b01);
    chk("t3_last3", rsp_last, 1);
    chk("t3_err3", rsp_err, 0);
    chk("t3_busy3", busy, 2'b00);

    // ---- SLVERR on one beat, reported only with last
    set_req(0, 32'h0000_3000, 8'd3);
    req_val = 2'b01;
    #1;
    chk("t4_gnt", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    tick();
    beat(4'd0, 32'hD0, 1'b0, 2'd0);
    beat(4'd0, 32'hD1, 1'b0, 2'd0);
    beat(4'd0, 32'hD2, 1'b0, 2'b10);
    chk("t4_err_mid", rsp_err, 0);
    chk("t4_last_mid", rsp_last, 0);
    chk("t4_proto_mid", proto_err, 0);
    beat(4'd0, 32'hD3, 1'b1, 2'd0);
    chk("t4_last", rsp_last, 1);
    chk("t4_err_last", rsp_err, 1);
    chk("t4_proto_last", proto_err, 0);
    chk("t4_busy", busy, 2'b00);

    // ---- early last, then stray and out-of-range beats
    set_req(0, 32'h0000_4000, 8'd3);
    req_val = 2'b01;
    #1;
    chk("t5_gnt_wrap", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    tick();
    beat(4'd0, 32'hE0, 1'b0, 2'd0);
    chk("t5_proto_b0", proto_err, 0);
    beat(4'd0, 32'hE1, 1'b1, 2'd0);
    chk("t5_early_proto", proto_err, 1);
    chk("t5_early_last", rsp_last, 1);
    chk("t5_early_err", rsp_err, 1);
    chk("t5_early_val", rsp_val, 2'b01);
    chk("t5_busy", busy, 2'b00);
    tick();
    chk("t5_proto_pulse", proto_err, 0);
    beat(4'd1, 32'hEE, 1'b1, 2'd0);
    chk("t5_stray_proto", proto_err, 1);
    chk("t5_stray_val", rsp_val, 2'b00);
    beat(4'd5, 32'hEF, 1'b1, 2'd0);
    chk("t5_oor_proto", proto_err, 1);
    chk("t5_oor_val", rsp_val, 2'b00);

    // ---- overlong burst: len 0 but first beat not last
    set_req(0, 32'h0000_5000, 8'd0);
    req_val = 2'b01;
    tick();
    req_val = 2'b00;
    tick();
    beat(4'd0, 32'hF0, 1'b0, 2'd0);
    chk("t5_long_proto", proto_err, 1);
    chk("t5_long_last", rsp_last, 1);
    chk("t5_long_err", rsp_err, 1);
    chk("t5_long_val", rsp_val, 2'b01);
    chk("t5_long_busy", busy, 2'b00);
    beat(4'd0, 32'hF1, 1'b1, 2'd0);
    chk("t5_after_proto", proto_err, 1);
    chk("t5_after_val", rsp_val, 2'b00);

    // ---- reset mid-burst
    set_req(0, 32'h0000_6000, 8'd3);
    req_val = 2'b01;
    tick();
    req_val = 2'b00;
    tick();
    beat(4'd0, 32'h60, 1'b0, 2'd0);
    beat(4'd0, 32'h61, 1'b0, 2'd0);
    chk("t6_pre_busy", busy, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", busy, 2'b00);
    chk("t6_rst_val", rsp_val, 2'b00);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_last", rsp_last, 0);
    chk("t6_rst_err", rsp_err, 0);
    chk("t6_rst_proto", proto_err, 0);
    chk("t6_rst_ar", biu_ext_ar_valid, 0);
    beat(4'd0, 32'h62, 1'b0, 2'd0);
    chk("t6_late_proto0", proto_err, 1);
    chk("t6_late_val0", rsp_val, 2'b00);
    beat(4'd0, 32'h63, 1'b1, 2'd0);
    chk("t6_late_proto1", proto_err, 1);
    chk("t6_late_val1", rsp_val, 2'b00);
    tick();
    chk("t6_quiet", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c7bbiu_axi_rd_engine.md
Name: c7bbiu_axi_rd_engine

Overview:
Parametrised AXI read-path engine for the c7bbiu BIU. It accepts read requests from NUM_SRC requesters (IFU, LSU, future prefetcher), arbitrates them round-robin and holds each AR beat stable until the slave accepts it. It allows one outstanding burst per source, counts R beats per source against the requested length, and returns registered per-beat data with error status to the owning requester.

Parameters:
NUM_SRC, 2, number of requesters; source index doubles as AXI ID (0=IFU, 1=LSU)
ADDR_W, 32, address width
DATA_W, 32, R data width
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_SRC

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_val  in  NUM_SRC  per-source read request valid
req_addr  in  NUM_SRC*ADDR_W  per-source address, source i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_SRC*8  per-source AXI len (beats-1)
req_size  in  NUM_SRC*3  per-source AXI size
req_burst  in  NUM_SRC*2  per-source AXI burst type
req_rdy  out  NUM_SRC  one-hot grant; request i accepted when req_val[i]&req_rdy[i]
ext_biu_ar_ready  in  1  AR ready
biu_ext_ar_valid  out  1  AR valid
biu_ext_ar_id  out  ID_W  AR id = granted source index
biu_ext_ar_addr  out  ADDR_W  AR address
biu_ext_ar_len  out  8  AR len
biu_ext_ar_size  out  3  AR size
biu_ext_ar_burst  out  2  AR burst
biu_ext_ar_lock  out  1  constant 0
biu_ext_ar_cache  out  4  constant 0
biu_ext_ar_prot  out  3  constant 0
biu_ext_r_ready  out  1  constant 1
ext_biu_r_valid  in  1  R valid
ext_biu_r_id  in  ID_W  R id
ext_biu_r_data  in  DATA_W  R data
ext_biu_r_last  in  1  R last
ext_biu_r_resp  in  2  R resp
rsp_val  out  NUM_SRC  one-hot registered beat valid to owning source
rsp_data  out  DATA_W  registered beat data
rsp_last  out  1  final beat of burst
rsp_err  out  1  burst error; meaningful only with rsp_last
busy  out  NUM_SRC  source i has a burst in flight
proto_err  out  1  one-cycle pulse on protocol violation by slave

Behaviour:
- Reset (synchronous, active-high): biu_ext_ar_valid=0, AR fields=0, rsp_val=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0, proto_err=0, RR pointer=0, all beat counters and sticky errors cleared. A reset mid-burst drops all tracking; late R beats after reset count as unexpected (proto_err).
- AR slot free = ~ar_valid_q | ext_biu_ar_ready.
- Eligible source i = req_val[i] & ~busy[i].
- Grant when slot free: the first eligible source at or after the RR pointer, scanning upward with wrap. req_rdy is combinational, at most one bit set, 0 when the slot is not free.
- On grant: latch addr/len/size/burst/id into the AR register, set ar_valid_q, set busy[g], load len_q[g]=req_len, clear beat_cnt[g] and err_q[g], move RR pointer to g+1 mod NUM_SRC.
- Latency: request accepted in cycle N, AR valid in N+1.
- AR valid and fields hold stable until ext_biu_ar_ready. Grant in the same cycle as the AR handshake is allowed (back-to-back AR).
- R beat accepted when ext_biu_r_valid (r_ready=1). Let s=ext_biu_r_id.
  - If s>=NUM_SRC or ~busy[s]: beat dropped, proto_err pulses next cycle, no rsp_val.
  - Otherwise, next cycle: rsp_val[s]=1, rsp_data=data, rsp_last=last. err_q[s] |= (resp!=0).
  - If beat_cnt[s]==len_q[s] and last: normal end.
  - If last with beat_cnt[s]<len_q[s] (early last): proto_err pulses, error recorded, burst terminates.
  - If beat_cnt[s]==len_q[s] and ~last: proto_err pulses, beat forwarded with rsp_last=1, burst force-terminated; further beats for s are unexpected.
  - On termination: rsp_err = err_q[s] | resp!=0 | mismatch; busy[s] clears at the same edge that registers rsp_last.
  - beat_cnt width is 8 bits; increments per accepted beat; does not wrap because of the len compare.
- A source may be re-granted in the cycle after its busy clears; no same-cycle grant on the terminating beat.
- Data interleaving across IDs is supported; each source's counters are independent.

Test Plan:
- Reset, then req_val=01 (IFU, addr 0x1C000000, len 3), ar_ready=1 -> req_rdy=01 same cycle; AR valid next cycle with id 0, len 3; 4 R beats id 0, resp 0 -> rsp_val=01 ×4 delayed 1 cycle, rsp_last on the 4th, rsp_err=0, busy[0] clears.
- req_val=11 for consecutive grants, ar_ready=0 for 5 cycles -> IFU granted first; AR fields stable for 5 cycles; LSU req_rdy=0 until the handshake; LSU AR is issued the cycle after, pointer=0.
- Both bursts in flight, R beats interleaved id 1,0,1,0 (len 1 each) -> rsp_val alternates 10,01,10,01; each last is correct; busy returns to 00.
- IFU len 3, beat 2 returns resp=2'b10 -> rsp_err=1 on the 4th beat only; proto_err stays 0.
- IFU len 3, last on beat 2 -> proto_err pulse, rsp_last=1, rsp_err=1; stray R beat id 1 with LSU idle -> proto_err pulse, no rsp_val.
- Assert reset while IFU is mid-burst (2 of 4 beats) -> all outputs zero next cycle; remaining beats give proto_err pulses.
